// File: rtl/cnt_5s_ctrl.sv
// rtl/cnt_5s_ctrl.sv - clk_out divider and round/abort/timeout sequencer for the 5 s interval counter
module cnt_5s_ctrl #(
    parameter int DIV_HALF      = 25_000_000,
    parameter int ROUNDS        = 1,
    parameter int TIMEOUT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cnt_out_5s,
    output logic       clk_out,
    output logic       en_cnt_5s,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic [3:0] round_cnt
);
    localparam int              DW       = $clog2(DIV_HALF);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV_HALF - 1);
    localparam logic [3:0]      ROUNDS_L = 4'(ROUNDS);
    localparam logic [3:0]      TMO_LAST = 4'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] div_cnt;
    logic          div_wrap;
    logic          tick_fall;
    logic          ack_meta;
    logic          ack_s;
    logic          start_pend;
    logic          abort_pend;
    logic          aborted;
    logic [3:0]    tmo_cnt;
    logic          tmo_last;
    logic          seq_end;
    logic          go_run;
    logic          finish;
    logic          next_round;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign tick_fall = div_wrap & clk_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            clk_out <= ~clk_out;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // cnt_out_5s lives in the clk_out domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= cnt_out_5s;
            ack_s    <= ack_meta;
        end
    end

    assign tmo_last   = (tmo_cnt == TMO_LAST);
    assign seq_end    = aborted | timeout_err | (round_cnt == ROUNDS_L);
    assign go_run     = tick_fall & (state == S_IDLE) & start_pend;
    assign finish     = tick_fall & (state == S_CLEAR) & ~ack_s & seq_end;
    assign next_round = tick_fall & (state == S_CLEAR) & ~ack_s & ~seq_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions only on tick_fall so en_cnt_5s is settled around every clk_out rise
    always_comb begin
        state_nxt = state;
        if (tick_fall) begin
            case (state)
                S_IDLE:  if (start_pend) state_nxt = S_RUN;
                S_RUN:   if (ack_s || abort_pend || tmo_last) state_nxt = S_CLEAR;
                S_CLEAR: if (!ack_s) state_nxt = seq_end ? S_IDLE : S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        en_cnt_5s = (state == S_RUN);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pend  <= 1'b0;
            abort_pend  <= 1'b0;
            aborted     <= 1'b0;
            tmo_cnt     <= 4'd0;
            round_cnt   <= 4'd0;
            timeout_err <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= finish & ~aborted & ~timeout_err;

            if (go_run) begin
                start_pend <= 1'b0;
            end else if (start && state == S_IDLE) begin
                start_pend <= 1'b1;
            end

            if (finish) begin
                abort_pend <= 1'b0;
            end else if (abort && state != S_IDLE) begin
                abort_pend <= 1'b1;
            end

            if (go_run) begin
                round_cnt   <= 4'd0;
                timeout_err <= 1'b0;
                tmo_cnt     <= 4'd0;
            end

            // Ack outranks abort and timeout on the same tick
            if (tick_fall && state == S_RUN) begin
                if (ack_s) begin
                    round_cnt <= round_cnt + 4'd1;
                end else if (abort_pend) begin
                    aborted <= 1'b1;
                end else if (tmo_last) begin
                    timeout_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 4'd1;
                end
            end

            if (finish) begin
                aborted <= 1'b0;
            end

            if (next_round) begin
                tmo_cnt <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_cnt_5s_ctrl.sv
// tb/tb_cnt_5s_ctrl.sv - bench for cnt_5s_ctrl: one-round and three-round instances with behavioural 5 s counters
module tb_cnt_5s_ctrl;
    localparam int DH  = 4;
    localparam int TMO = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       tie0;
    logic       co   [2];
    logic       en   [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];
    logic [3:0] rc   [2];
    logic       fl0, fl1, cin0, cin1;
    int         cc0, cc1;

    int errors = 0;
    int checks = 0;

    assign cin0 = fl0 & ~tie0;
    assign cin1 = fl1 & ~tie0;

    cnt_5s_ctrl #(.DIV_HALF(DH), .ROUNDS(1), .TIMEOUT_TICKS(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cnt_out_5s(cin0),
        .clk_out(co[0]), .en_cnt_5s(en[0]), .busy(busy[0]), .done(done[0]),
        .timeout_err(err[0]), .round_cnt(rc[0])
    );

    cnt_5s_ctrl #(.DIV_HALF(DH), .ROUNDS(3), .TIMEOUT_TICKS(TMO)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cnt_out_5s(cin1),
        .clk_out(co[1]), .en_cnt_5s(en[1]), .busy(busy[1]), .done(done[1]),
        .timeout_err(err[1]), .round_cnt(rc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 5 s counter: flag on the 6th enabled clk_out rise, cleared by a rise with enable low
    always @(posedge co[0] or negedge rst_n) begin
        if (!rst_n || !en[0]) begin
            cc0 <= 0;
            fl0 <= 1'b0;
        end else begin
            cc0 <= cc0 + 1;
            if (cc0 + 1 >= 6) fl0 <= 1'b1;
        end
    end

    always @(posedge co[1] or negedge rst_n) begin
        if (!rst_n || !en[1]) begin
            cc1 <= 0;
            fl1 <= 1'b0;
        end else begin
            cc1 <= cc1 + 1;
            if (cc1 + 1 >= 6) fl1 <= 1'b1;
        end
    end

    // Period-level model: k = clk cycles since reset release; clk_out falls every 2*DH cycles
    int k;
    int m_ph   [2];
    int m_per  [2];
    int m_rc   [2];
    bit m_err  [2];
    bit m_done [2];
    bit m_sreq [2];
    bit m_areq [2];
    bit m_abd  [2];
    bit fall, was_busy, took, ended;
    int rnds;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_per[i] = 0; m_rc[i] = 0; m_err[i] = 0; m_done[i] = 0;
                m_sreq[i] = 0; m_areq[i] = 0; m_abd[i] = 0;
            end
        end else begin
            k = k + 1;
            fall = (k % (2 * DH)) == 0;
            for (int i = 0; i < 2; i++) begin
                rnds = (i == 0) ? 1 : 3;
                was_busy = (m_ph[i] != 0);
                took = 0;
                ended = 0;
                m_done[i] = 0;
                if (fall) begin
                    if (m_ph[i] == 0) begin
                        if (m_sreq[i]) begin
                            m_ph[i] = 1; m_per[i] = 0; m_rc[i] = 0; m_err[i] = 0;
                            m_sreq[i] = 0; took = 1;
                        end
                    end else if (m_ph[i] == 1) begin
                        m_per[i] = m_per[i] + 1;
                        if (!tie0 && m_per[i] >= 6) begin
                            m_ph[i] = 2; m_rc[i] = m_rc[i] + 1;
                        end else if (m_areq[i]) begin
                            m_ph[i] = 2; m_abd[i] = 1;
                        end else if (m_per[i] >= TMO) begin
                            m_ph[i] = 2; m_err[i] = 1;
                        end
                    end else begin
                        if (m_abd[i] || m_err[i] || m_rc[i] == rnds) begin
                            m_ph[i] = 0; m_done[i] = !m_abd[i] && !m_err[i];
                            m_abd[i] = 0; m_areq[i] = 0; ended = 1;
                        end else begin
                            m_ph[i] = 1; m_per[i] = 0;
                        end
                    end
                end
                if (!took && start && !was_busy) m_sreq[i] = 1;
                if (!ended && abort && was_busy) m_areq[i] = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int hi_len [2][4];
    int gap    [2][4];
    int rc_seq [2][4];
    int n_hi [2], n_gap [2], n_rc [2];
    int first_rise [2], last_rise [2], last_fall [2];
    int done_cnt [2], done_at [2], err_at [2], idle_at [2];
    int co_r [2];
    int n_co;
    logic en_p [2], busy_p [2], err_p [2], co_p;
    logic [3:0] rc_p [2];

    // Runs n cycles comparing both DUTs to the model at each falling clk edge, gathering event timing
    task automatic observe(input int n, input int start_at, input int abort_off);
        n_co = 0; co_r[0] = -1; co_r[1] = -1; co_p = co[0];
        for (int i = 0; i < 2; i++) begin
            n_hi[i] = 0; n_gap[i] = 0; n_rc[i] = 0; first_rise[i] = -1; last_rise[i] = -1;
            last_fall[i] = -1; done_cnt[i] = 0; done_at[i] = -1; err_at[i] = -1; idle_at[i] = -1;
            en_p[i] = en[i]; busy_p[i] = busy[i]; err_p[i] = err[i]; rc_p[i] = rc[i];
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d clk_out c%0d", i, c), co[i], (k / DH) % 2);
                chk($sformatf("u%0d en_cnt_5s c%0d", i, c), en[i], m_ph[i] == 1);
                chk($sformatf("u%0d busy c%0d", i, c), busy[i], m_ph[i] != 0);
                chk($sformatf("u%0d done c%0d", i, c), done[i], m_done[i]);
                chk($sformatf("u%0d timeout_err c%0d", i, c), err[i], m_err[i]);
                chk($sformatf("u%0d round_cnt c%0d", i, c), rc[i], m_rc[i]);
                if (en[i] && !en_p[i]) begin
                    if (first_rise[i] < 0) first_rise[i] = c;
                    if (n_hi[i] > 0 && n_gap[i] < 4) begin
                        gap[i][n_gap[i]] = c - last_fall[i];
                        n_gap[i]++;
                    end
                    last_rise[i] = c;
                end
                if (!en[i] && en_p[i]) begin
                    if (n_hi[i] < 4) begin
                        hi_len[i][n_hi[i]] = c - last_rise[i];
                        n_hi[i]++;
                    end
                    last_fall[i] = c;
                end
                if (done[i]) begin done_cnt[i]++; done_at[i] = c; end
                if (rc[i] != rc_p[i] && n_rc[i] < 4) begin
                    rc_seq[i][n_rc[i]] = rc[i];
                    n_rc[i]++;
                end
                if (err[i] && !err_p[i]) err_at[i] = c;
                if (!busy[i] && busy_p[i]) idle_at[i] = c;
                en_p[i] = en[i]; busy_p[i] = busy[i]; err_p[i] = err[i]; rc_p[i] = rc[i];
            end
            if (co[0] && !co_p && n_co < 2) begin
                co_r[n_co] = c + 1;
                n_co++;
            end
            co_p = co[0];
            start = (c == start_at);
            abort = (abort_off >= 0) && (first_rise[0] >= 0) && (c == first_rise[0] + abort_off);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; tie0 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset u%0d clk_out", i), co[i], 0);
            chk($sformatf("reset u%0d en_cnt_5s", i), en[i], 0);
            chk($sformatf("reset u%0d busy", i), busy[i], 0);
            chk($sformatf("reset u%0d done", i), done[i], 0);
            chk($sformatf("reset u%0d timeout_err", i), err[i], 0);
            chk($sformatf("reset u%0d round_cnt", i), rc[i], 0);
        end
        rst_n = 1'b1;

        observe(30, -1, -1);
        chk("first clk_out rise", co_r[0], 4);
        chk("clk_out period", co_r[1] - co_r[0], 8);

        observe(240, 2, -1);
        chk("u0 enable windows", n_hi[0], 1);
        chk("u0 enable length", hi_len[0][0], 48);
        chk("u0 done count", done_cnt[0], 1);
        chk("u0 done after enable", done_at[0] - first_rise[0], 56);
        chk("u0 round_cnt end", rc[0], 1);
        chk("u0 busy end", busy[0], 0);
        chk("u1 round_cnt steps", n_rc[1], 3);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("u1 round_cnt step %0d", r), rc_seq[1][r], r + 1);
            chk($sformatf("u1 enable length %0d", r), hi_len[1][r], 48);
        end
        chk("u1 gap count", n_gap[1], 2);
        chk("u1 gap 0", gap[1][0], 8);
        chk("u1 gap 1", gap[1][1], 8);
        chk("u1 done count", done_cnt[1], 1);

        tie0 = 1'b1;
        observe(120, 2, -1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d timeout at", i), err_at[i] - first_rise[i], 64);
            chk($sformatf("u%0d idle after timeout", i), idle_at[i] - first_rise[i], 72);
            chk($sformatf("u%0d timeout done", i), done_cnt[i], 0);
            chk($sformatf("u%0d timeout round_cnt", i), rc[i], 0);
            chk($sformatf("u%0d timeout_err sticky", i), err[i], 1);
        end
        tie0 = 1'b0;

        observe(80, 2, 20);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d abort enable length", i), hi_len[i][0], 24);
            chk($sformatf("u%0d idle after abort", i), idle_at[i] - first_rise[i], 32);
            chk($sformatf("u%0d abort done", i), done_cnt[i], 0);
            chk($sformatf("u%0d abort round_cnt", i), rc[i], 0);
            chk($sformatf("u%0d start clears timeout_err", i), err[i], 0);
        end

        observe(240, 2, -1);
        chk("u0 after abort done", done_cnt[0], 1);
        chk("u0 after abort round_cnt", rc[0], 1);
        chk("u1 after abort done", done_cnt[1], 1);
        chk("u1 after abort round_cnt", rc[1], 3);

        observe(30, 2, -1);
        for (int w = 0; w < 8 && co[0] !== 1'b1; w++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d async reset en_cnt_5s", i), en[i], 0);
            chk($sformatf("u%0d async reset busy", i), busy[i], 0);
            chk($sformatf("u%0d async reset clk_out", i), co[i], 0);
        end
        observe(3, -1, -1);
        rst_n = 1'b1;
        observe(100, -1, -1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d no done after reset", i), done_cnt[i], 0);
            chk($sformatf("u%0d no enable after reset", i), n_hi[i] + (en[i] ? 1 : 0), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cnt_5s_ctrl.md
# cnt_5s_ctrl

Sequencer that drives the 5-second interval counter. It derives the 1 s counter clock `clk_out` from the system clock. It asserts and releases `en_cnt_5s` on safe edges, consumes the counter's `cnt_out_5s` completion flag, and runs a programmable number of back-to-back 5 s rounds. It also provides abort and timeout supervision, and reports status to the top-level control.

## Interface
- `DIV_HALF`, default 25_000_000: `clk` cycles per half period of `clk_out`. Allowed range ≥ 3. The default gives 1 s from 50 MHz.
- `ROUNDS`, default 1: number of 5 s intervals per start. Allowed range 1..15.
- `TIMEOUT_TICKS`, default 8: maximum `clk_out` periods in RUN without completion. Allowed range 7..15.
- `clk`  in  1  system clock. All logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sequence. Sampled every `clk`.
- `abort`  in  1  cancel a running sequence. Sampled every `clk`.
- `cnt_out_5s`  in  1  completion flag from the 5 s counter (`clk_out` domain).
- `clk_out`  out  1  divided clock with 50 % duty that feeds the 5 s counter.
- `en_cnt_5s`  out  1  counter enable.
- `busy`  out  1  high in RUN and CLEAR.
- `done`  out  1  one-`clk` pulse on normal completion of all rounds.
- `timeout_err`  out  1  sticky error flag. Cleared on an accepted start.
- `round_cnt`  out  4  number of completed rounds in the current or last sequence.

## Operation
- Divider: `div_cnt` counts 0..DIV_HALF-1, then wraps and toggles `clk_out`. It runs free from reset.
  - `tick_fall` is an internal one-cycle strobe. It is asserted on the `clk` cycle in which `clk_out` is toggled from 1 to 0.
- `cnt_out_5s` passes through a two-flop synchronizer to produce `ack_s`.
- `start` and `abort` are captured into `start_pend` and `abort_pend`. FSM transitions and `en_cnt_5s` updates happen only on `tick_fall`. This guarantees that `en_cnt_5s` is stable for a half period around each `clk_out` rising edge.
- Downstream counter contract:
  - The counter raises `cnt_out_5s` on the 6th `clk_out` rising edge after it sees `en_cnt_5s` high.
  - `cnt_out_5s` stays high until a `clk_out` rising edge occurs with `en_cnt_5s` low.
- FSM states: IDLE, RUN, CLEAR. `en_cnt_5s` is 1 only in RUN.
  - **IDLE:** On `tick_fall` with `start_pend`, go to RUN. Set `round_cnt`=0, `timeout_err`=0, `tmo_cnt`=0, and clear `start_pend`.
  - **RUN:** Evaluated on `tick_fall`, in this priority order:
    - If `ack_s`=1: go to CLEAR and increment `round_cnt`.
    - Else if `abort_pend`: go to CLEAR with `aborted`=1.
    - Else if `tmo_cnt`==TIMEOUT_TICKS-1: go to CLEAR and set `timeout_err`=1.
    - Else: increment `tmo_cnt`.
  - **CLEAR:** On `tick_fall` with `ack_s`=0:
    - If `aborted`, `timeout_err`, or `round_cnt`==ROUNDS: go to IDLE. Pulse `done` only if none of the error or abort flags is set. Clear `aborted` and `abort_pend`.
    - Else: go to RUN with `tmo_cnt`=0.
  - If `ack_s` is still 1 in CLEAR, the FSM stays in CLEAR.
- `start` while `busy` is ignored and does not set `start_pend`. `abort` in IDLE is ignored.
- `start` and `abort` in the same cycle while in IDLE: `start` is taken and `abort` is dropped.
- `ack_s` and a timeout on the same `tick_fall`: the ack wins. The round counts and no error is raised.
- `round_cnt` never wraps, because ROUNDS ≤ 15.

## Timing
- Reset (asynchronous, on `rst_n` low) drives the following values immediately:
  - outputs: `clk_out`=0, `en_cnt_5s`=0, `busy`=0, `done`=0, `timeout_err`=0, `round_cnt`=0;
  - internal state: FSM=IDLE, all pending flags, counters, and synchronizer flops=0.
- First `clk_out` rise occurs DIV_HALF `clk` cycles after reset release. Period is 2·DIV_HALF.
- Start latency: `en_cnt_5s` rises at the first `tick_fall` after `start`, at most 2·DIV_HALF cycles later.
- One round:
  - `en_cnt_5s` rises at F0.
  - Counter flag rises at the 6th rising edge. RUN→CLEAR occurs at F6.
  - Counter clears at the 7th rising edge. CLEAR exits at F7.
  - Between rounds, `en_cnt_5s` is low for exactly one `clk_out` period.
- `done` is high for the single `clk` cycle after the final CLEAR→IDLE transition.

## Test plan
- **Reset:** with DIV_HALF=4, hold `rst_n` low, then release. Required: all outputs 0, and `clk_out` first rises 4 `clk` cycles after release, with period 8.
- **Single round:** DIV_HALF=4, ROUNDS=1, behavioural 5 s counter attached, pulse `start`. Required: `en_cnt_5s` high for 6 `clk_out` periods; then one `done` pulse at the 7th `tick_fall` after `en_cnt_5s` rises; `round_cnt`=1; `busy` low afterwards.
- **Multiple rounds:** ROUNDS=3. Required: `round_cnt` steps 1, 2, 3; `en_cnt_5s` is low for one `clk_out` period between rounds; exactly one `done`.
- **Timeout:** `cnt_out_5s` tied to 0, TIMEOUT_TICKS=8. Required: `timeout_err`=1 at the 8th `tick_fall` in RUN; FSM back in IDLE one period later; no `done`; `round_cnt`=0.
- **Abort:** pulse `abort` during period 3 of RUN. Required: `en_cnt_5s` drops at the next `tick_fall`; IDLE one period later; no `done`; `round_cnt` unchanged. A later `start` runs normally.
- **Reset mid-operation:** drop `rst_n` mid-RUN. Required: `en_cnt_5s`, `busy`, and `clk_out` go to 0 immediately; no `done` after release.
